elastic_pipe: RTL
=================

Name: elastic_pipe

Overview:
- Parametrised successor to the plain enable-gated pipeline register.
- Adds a per-stage valid/ready handshake, bubble collapsing (an empty stage loads even while downstream is stalled), a synchronous flush and an occupancy counter.
- Sits between datapath units, e.g. the matrix-multiply/FP units and their consumers, where latency must be retimeable but backpressure must not drop data.

Parameters:
- WIDTH, 64: payload bit width (>=1).
- DEPTH, 2: number of register stages (0..16); 0 = combinational passthrough.
- RESET_DATA, 0: value loaded into every stage data register on reset.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous pipeline clear.
- in_valid  input  1  upstream has data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  last stage holds data.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload of the last stage (skid entry when the optional feature is enabled, see below).
- occupancy  output  OCC_W  number of items held; OCC_W = $clog2(CAP+1), where CAP = DEPTH (DEPTH+1 with skid).

Behaviour:
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Per-stage state: valid bit v[i] and data d[i]; stage 0 is the input side, stage DEPTH-1 is the output.
- Advance rule: stage i accepts new data when adv[i] = ~v[i] | (downstream accepting), where downstream accepting is adv[i+1] for inner stages and out_ready for the last stage.
- On adv[i]: v[i] <= upstream valid, and d[i] <= upstream data when upstream is valid; data holds otherwise.
- in_ready = adv[0] & ~flush.
- out_valid = v[DEPTH-1] & ~flush; out_data = d[DEPTH-1].
- Latency: DEPTH cycles with no stall. Throughput: 1 item/cycle under continuous out_ready.
- Full: all v set and out_ready=0 -> in_ready=0; no stage changes.
- Empty: out_valid=0, occupancy=0; in_ready=1 regardless of out_ready.
- Simultaneous in_fire and out_fire when full: accepted (ready chains combinationally through the stages); occupancy unchanged.
- Reset: all v=0, all d=RESET_DATA, occupancy=0. Hence out_valid=0, in_ready=1 and out_data=RESET_DATA on the cycle after rst. rst overrides flush and any handshake, including mid-transfer.
- Flush: in the flush cycle in_ready=0 and out_valid=0, so no fire occurs. The next cycle all v=0 and occupancy=0; d is retained.
- Occupancy: registered, +1 on in_fire, -1 on out_fire, both in the same cycle -> unchanged. It never exceeds CAP or wraps.
- DEPTH=0: in_ready=out_ready & ~flush, out_valid=in_valid & ~flush & ~rst, out_data=in_data, occupancy=0.

Optional Feature:
- Macro: ELASTIC_PIPE_SKID_EN.
- Defined:
  - A one-entry skid register sits at the output, so out_ready has no combinational path to in_ready.
  - in_ready becomes a flop, set = skid empty.
  - When the last stage advances while out_ready=0, the item lands in the skid; out_data/out_valid are then taken from the skid first (FIFO order preserved).
  - CAP = DEPTH+1. Latency with no stall is unchanged.
  - Reset and flush also clear the skid.
- Undefined: behaviour exactly as above.

Decomposition:
- Package elastic_pipe_pkg holds:
  - MAX_DEPTH = 16.
  - function occ_width(depth, skid).
  - typedef of stage state struct {valid, data} (data width via parameterised type in the module).
- Sub-module elastic_pipe_stage: one valid/data register with adv logic, reset and flush. elastic_pipe instantiates DEPTH of these in a generate loop, plus the counter and optional skid.

Test Plan:
- Streaming: DEPTH=3, out_ready=1, in_data=1..10 back-to-back -> out_data 1..10 on cycles 3..12, no gaps; occupancy steady at 3.
- Stall/fill: DEPTH=3, out_ready=0 with 5 items offered -> in_ready drops after 3 fires, occupancy=3. Raise out_ready -> items 1,2,3 then 4,5 out in order, no loss or duplication.
- Bubble collapse: send item A, idle 2 cycles, send B, out_ready=0 -> B advances until it sits directly behind A; occupancy=2.
- Flush: occupancy=3, pulse flush one cycle with in_valid=1 -> no fire that cycle; next cycle out_valid=0, occupancy=0, in_ready=1.
- Reset mid-stall: full pipe, assert rst one cycle -> next cycle out_valid=0, out_data=RESET_DATA (0), occupancy=0. Subsequent item emerges after DEPTH cycles.
- Skid (macro on), DEPTH=2:
  - Toggle out_ready 1/0 every cycle under continuous input -> in_ready is a registered signal (changes only after a clock edge, never within a cycle in response to out_ready); order preserved.
  - occupancy peaks at 3 (CAP = DEPTH+1).

Source files
------------

// File: rtl/elastic_pipe_pkg.sv
// elastic_pipe_pkg: shared constants and helpers for elastic_pipe.
// ELASTIC_PIPE_SKID_EN selects the registered-ready output skid.
package elastic_pipe_pkg;

  localparam int MAX_DEPTH = 16;

`ifdef ELASTIC_PIPE_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  // Counter width for CAP items; a passthrough still gets one bit.
  function automatic int occ_width(input int depth, input bit skid);
    int cap;
    cap = (depth == 0) ? 0 : depth + (skid ? 1 : 0);
    return (cap < 1) ? 1 : $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: one valid/data register with its advance logic.
// Flush clears valid only; data is kept.
module elastic_pipe_stage
  import elastic_pipe_pkg::*;
#(
  parameter int              WIDTH      = 64,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_acc_i,
  output logic             adv_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t st_q, st_d;

  assign adv_o   = ~st_q.valid | dn_acc_i;
  assign valid_o = st_q.valid;
  assign data_o  = st_q.data;

  always_comb begin
    st_d = st_q;
    if (flush_i) begin
      st_d.valid = 1'b0;
    end else if (adv_o) begin
      st_d.valid = up_valid_i;
      if (up_valid_i) st_d.data = up_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q.valid <= 1'b0;
      st_q.data  <= RESET_DATA;
    end else begin
      st_q <= st_d;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe: valid/ready register pipeline with bubble collapse,
// flush and occupancy count. ELASTIC_PIPE_SKID_EN adds an output skid.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  localparam int              OCC_W      = occ_width(DEPTH, SKID_EN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH == 0) begin : g_pass
    assign in_ready  = out_ready & ~flush;
    assign out_valid = in_valid & ~flush & ~rst;
    assign out_data  = in_data;
    assign occupancy = '0;
  end else begin : g_pipe
    logic             in_fire;
    logic             out_fire;
    logic             head_adv;
    logic             last_acc;
    logic             last_v;
    logic [WIDTH-1:0] last_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_st
      logic             up_v;
      logic [WIDTH-1:0] up_d;
      logic             dn_acc;
      logic             adv;
      logic             v;
      logic [WIDTH-1:0] d;

      if (i == 0) begin : g_head
        assign up_v = in_fire;
        assign up_d = in_data;
      end else begin : g_body
        assign up_v = g_st[i-1].v;
        assign up_d = g_st[i-1].d;
      end

      if (i == DEPTH - 1) begin : g_tail
        assign dn_acc = last_acc;
      end else begin : g_inner
        assign dn_acc = g_st[i+1].adv;
      end

      elastic_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_DATA(RESET_DATA)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .up_valid_i(up_v),
        .up_data_i (up_d),
        .dn_acc_i  (dn_acc),
        .adv_o     (adv),
        .valid_o   (v),
        .data_o    (d)
      );
    end

    assign head_adv = g_st[0].adv;
    assign last_v   = g_st[DEPTH-1].v;
    assign last_d   = g_st[DEPTH-1].d;

`ifdef ELASTIC_PIPE_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;
    logic             unused_head_adv;

    // Ready depends only on the skid flop, never on out_ready.
    assign unused_head_adv = head_adv;
    assign last_acc  = ~skid_v_q;
    assign in_ready  = ~skid_v_q & ~flush;
    assign out_valid = (skid_v_q | last_v) & ~flush;
    assign out_data  = skid_v_q ? skid_d_q : last_d;

    always_comb begin
      skid_v_d = skid_v_q;
      skid_d_d = skid_d_q;
      if (flush) begin
        skid_v_d = 1'b0;
      end else if (skid_v_q) begin
        if (out_ready) skid_v_d = 1'b0;
      end else if (last_v && !out_ready) begin
        skid_v_d = 1'b1;
        skid_d_d = last_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        skid_v_q <= 1'b0;
        skid_d_q <= RESET_DATA;
      end else begin
        skid_v_q <= skid_v_d;
        skid_d_q <= skid_d_d;
      end
    end
`else
    assign last_acc  = out_ready;
    assign in_ready  = head_adv & ~flush;
    assign out_valid = last_v & ~flush;
    assign out_data  = last_d;
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
      occ_d = occ_q;
      unique case (1'b1)
        flush:                occ_d = '0;
        in_fire & ~out_fire:  occ_d = occ_q + OCC_W'(1);
        out_fire & ~in_fire:  occ_d = occ_q - OCC_W'(1);
        default:              ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) occ_q <= '0;
      else     occ_q <= occ_d;
    end

    assign occupancy = occ_q;
  end

endmodule
